// File: rtl/regfile_write_queue.sv
// regfile_write_queue
//   Buffers register-file write requests from execute/memory in a small
//   circular FIFO and drains one entry per cycle onto the register file's
//   write port. It also provides a two-port bypass lookup, so decode sees
//   pending values that have not yet been written.
//
// Ports
//   clock, rst                 clock (rising edge), async active-low reset
//   in_valid/in_ready          request handshake; in_ready = !full
//   in_sel, in_data            destination register and write value
//   wr_stall                   register file refuses a write this cycle
//   wr_we, wr_sel, wr_data     register file write port (from head entry)
//   byp_sel_k, byp_hit_k,
//   byp_data_k                 bypass lookup; youngest matching entry wins
//   count, empty, full         registered occupancy
module regfile_write_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_sel,
  input  logic [31:0]   in_data,
  input  logic          wr_stall,
  output logic          wr_we,
  output logic [4:0]    wr_sel,
  output logic [31:0]   wr_data,
  input  logic [4:0]    byp_sel_1,
  input  logic [4:0]    byp_sel_2,
  output logic          byp_hit_1,
  output logic          byp_hit_2,
  output logic [31:0]   byp_data_1,
  output logic [31:0]   byp_data_2,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  localparam int PW = $clog2(DEPTH);

  logic [4:0]    sel_q  [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count_q;
  logic          push;
  logic          pop;
  logic [PW-1:0] scan_idx;

  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign in_ready = !full;

  // Writes to register 0 complete the handshake but are dropped.
  assign push = in_valid && in_ready && (in_sel != 5'd0);

  assign wr_we   = !empty && !wr_stall;
  assign wr_sel  = empty ? 5'd0  : sel_q[rd_ptr];
  assign wr_data = empty ? 32'd0 : data_q[rd_ptr];
  assign pop     = wr_we;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        sel_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (push) begin
        sel_q[wr_ptr]  <= in_sel;
        data_q[wr_ptr] <= in_data;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Scan oldest to youngest over occupied slots; a later match overrides an
  // earlier one, so the entry nearest the write pointer supplies the data.
  always_comb begin
    byp_hit_1  = 1'b0;
    byp_hit_2  = 1'b0;
    byp_data_1 = 32'd0;
    byp_data_2 = 32'd0;
    scan_idx   = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = rd_ptr + PW'(i);
      if (CW'(i) < count_q) begin
        if ((byp_sel_1 != 5'd0) && (sel_q[scan_idx] == byp_sel_1)) begin
          byp_hit_1  = 1'b1;
          byp_data_1 = data_q[scan_idx];
        end
        if ((byp_sel_2 != 5'd0) && (sel_q[scan_idx] == byp_sel_2)) begin
          byp_hit_2  = 1'b1;
          byp_data_2 = data_q[scan_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_queue.sv
// tb_regfile_write_queue
//   Table of directed vectors, a few multi-cycle corner sequences
//   (simultaneous accept/drain, mid-operation reset), then randomized traffic
//   compared against a queue-based reference model.
module tb_regfile_write_queue;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clock;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    in_sel;
  logic [31:0]   in_data;
  logic          wr_stall;
  logic          wr_we;
  logic [4:0]    wr_sel;
  logic [31:0]   wr_data;
  logic [4:0]    byp_sel_1;
  logic [4:0]    byp_sel_2;
  logic          byp_hit_1;
  logic          byp_hit_2;
  logic [31:0]   byp_data_1;
  logic [31:0]   byp_data_2;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;

  regfile_write_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clock(clock), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .wr_stall(wr_stall), .wr_we(wr_we), .wr_sel(wr_sel), .wr_data(wr_data),
    .byp_sel_1(byp_sel_1), .byp_sel_2(byp_sel_2),
    .byp_hit_1(byp_hit_1), .byp_hit_2(byp_hit_2),
    .byp_data_1(byp_data_1), .byp_data_2(byp_data_2),
    .count(count), .empty(empty), .full(full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic        v;
    logic [4:0]  s;
    logic [31:0] d;
    logic        st;
    logic [4:0]  b1;
    logic [4:0]  b2;
    int          cnt;
    logic        we;
    logic [4:0]  ws;
    logic [31:0] wd;
    logic        h1;
    logic [31:0] bd1;
    logic        h2;
    logic [31:0] bd2;
  } vec_t;

  typedef struct {
    logic [4:0]  sel;
    logic [31:0] data;
  } ent_t;

  ent_t mdl[$];
  vec_t tbl[23];

  function automatic vec_t mk(logic v, logic [4:0] s, logic [31:0] d, logic st,
                              logic [4:0] b1, logic [4:0] b2, int cnt, logic we,
                              logic [4:0] ws, logic [31:0] wd, logic h1,
                              logic [31:0] bd1, logic h2, logic [31:0] bd2);
    vec_t r;
    r.v = v; r.s = s; r.d = d; r.st = st; r.b1 = b1; r.b2 = b2;
    r.cnt = cnt; r.we = we; r.ws = ws; r.wd = wd;
    r.h1 = h1; r.bd1 = bd1; r.h2 = h2; r.bd2 = bd2;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input int cnt, input logic we, input logic [4:0] ws,
                           input logic [31:0] wd, input logic h1, input logic [31:0] bd1,
                           input logic h2, input logic [31:0] bd2);
    chk("count", 32'(count), 32'(cnt));
    chk("empty", 32'(empty), 32'(cnt == 0));
    chk("full", 32'(full), 32'(cnt == DEPTH));
    chk("in_ready", 32'(in_ready), 32'(cnt != DEPTH));
    chk("wr_we", 32'(wr_we), 32'(we));
    chk("wr_sel", 32'(wr_sel), 32'(ws));
    chk("wr_data", wr_data, wd);
    chk("byp_hit_1", 32'(byp_hit_1), 32'(h1));
    chk("byp_data_1", byp_data_1, bd1);
    chk("byp_hit_2", 32'(byp_hit_2), 32'(h2));
    chk("byp_data_2", byp_data_2, bd2);
  endtask

  task automatic drive(input logic v, input logic [4:0] s, input logic [31:0] d,
                       input logic st, input logic [4:0] b1, input logic [4:0] b2);
    in_valid = v; in_sel = s; in_data = d; wr_stall = st;
    byp_sel_1 = b1; byp_sel_2 = b2;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic model_expect(output int cnt, output logic we, output logic [4:0] ws,
                              output logic [31:0] wd, output logic h1, output logic [31:0] bd1,
                              output logic h2, output logic [31:0] bd2);
    cnt = mdl.size();
    we  = (cnt > 0) && !wr_stall;
    ws  = (cnt > 0) ? mdl[0].sel  : 5'd0;
    wd  = (cnt > 0) ? mdl[0].data : 32'd0;
    h1 = 1'b0; bd1 = 32'd0; h2 = 1'b0; bd2 = 32'd0;
    for (int i = cnt - 1; i >= 0; i--) begin
      if (!h1 && byp_sel_1 != 5'd0 && mdl[i].sel == byp_sel_1) begin
        h1 = 1'b1; bd1 = mdl[i].data;
      end
      if (!h2 && byp_sel_2 != 5'd0 && mdl[i].sel == byp_sel_2) begin
        h2 = 1'b1; bd2 = mdl[i].data;
      end
    end
  endtask

  task automatic model_update();
    logic acc, drn;
    acc = in_valid && (mdl.size() < DEPTH) && (in_sel != 5'd0);
    drn = (mdl.size() > 0) && !wr_stall;
    if (drn) void'(mdl.pop_front());
    if (acc) mdl.push_back('{sel: in_sel, data: in_data});
  endtask

  initial begin
    int          e_cnt;
    logic        e_we, e_h1, e_h2;
    logic [4:0]  e_ws;
    logic [31:0] e_wd, e_bd1, e_bd2;

    //            v  sel   data           st b1 b2  cnt we sel  wdata          h1 bd1            h2 bd2
    tbl[0]  = mk(1, 5'd5, 32'hDEADBEEF, 0, 0, 0,  0, 0, 5'd0, 32'h0,         0, 32'h0,         0, 32'h0);
    tbl[1]  = mk(0, 5'd0, 32'h0,        0, 5, 0,  1, 1, 5'd5, 32'hDEADBEEF,  1, 32'hDEADBEEF,  0, 32'h0);
    tbl[2]  = mk(0, 5'd0, 32'h0,        0, 5, 0,  0, 0, 5'd0, 32'h0,         0, 32'h0,         0, 32'h0);
    tbl[3]  = mk(1, 5'd1, 32'h11,       1, 0, 0,  0, 0, 5'd0, 32'h0,         0, 32'h0,         0, 32'h0);
    tbl[4]  = mk(1, 5'd2, 32'h22,       1, 0, 0,  1, 0, 5'd1, 32'h11,        0, 32'h0,         0, 32'h0);
    tbl[5]  = mk(1, 5'd3, 32'h33,       1, 0, 0,  2, 0, 5'd1, 32'h11,        0, 32'h0,         0, 32'h0);
    tbl[6]  = mk(1, 5'd4, 32'h44,       1, 0, 0,  3, 0, 5'd1, 32'h11,        0, 32'h0,         0, 32'h0);
    tbl[7]  = mk(1, 5'd6, 32'h66,       1, 0, 0,  4, 0, 5'd1, 32'h11,        0, 32'h0,         0, 32'h0);
    tbl[8]  = mk(0, 5'd0, 32'h0,        0, 6, 4,  4, 1, 5'd1, 32'h11,        0, 32'h0,         1, 32'h44);
    tbl[9]  = mk(0, 5'd0, 32'h0,        0, 0, 0,  3, 1, 5'd2, 32'h22,        0, 32'h0,         0, 32'h0);
    tbl[10] = mk(0, 5'd0, 32'h0,        0, 0, 0,  2, 1, 5'd3, 32'h33,        0, 32'h0,         0, 32'h0);
    tbl[11] = mk(0, 5'd0, 32'h0,        0, 0, 0,  1, 1, 5'd4, 32'h44,        0, 32'h0,         0, 32'h0);
    tbl[12] = mk(0, 5'd0, 32'h0,        0, 0, 0,  0, 0, 5'd0, 32'h0,         0, 32'h0,         0, 32'h0);
    tbl[13] = mk(1, 5'd7, 32'hAAAA,     1, 0, 0,  0, 0, 5'd0, 32'h0,         0, 32'h0,         0, 32'h0);
    tbl[14] = mk(1, 5'd7, 32'hBBBB,     1, 7, 0,  1, 0, 5'd7, 32'hAAAA,      1, 32'hAAAA,      0, 32'h0);
    tbl[15] = mk(0, 5'd0, 32'h0,        1, 7, 8,  2, 0, 5'd7, 32'hAAAA,      1, 32'hBBBB,      0, 32'h0);
    tbl[16] = mk(1, 5'd0, 32'h1234,     1, 0, 7,  2, 0, 5'd7, 32'hAAAA,      0, 32'h0,         1, 32'hBBBB);
    tbl[17] = mk(0, 5'd0, 32'h0,        1, 7, 0,  2, 0, 5'd7, 32'hAAAA,      1, 32'hBBBB,      0, 32'h0);
    tbl[18] = mk(0, 5'd0, 32'h0,        0, 0, 0,  2, 1, 5'd7, 32'hAAAA,      0, 32'h0,         0, 32'h0);
    tbl[19] = mk(0, 5'd0, 32'h0,        0, 0, 0,  1, 1, 5'd7, 32'hBBBB,      0, 32'h0,         0, 32'h0);
    tbl[20] = mk(0, 5'd0, 32'h0,        0, 0, 0,  0, 0, 5'd0, 32'h0,         0, 32'h0,         0, 32'h0);
    tbl[21] = mk(1, 5'd0, 32'h1234,     0, 0, 0,  0, 0, 5'd0, 32'h0,         0, 32'h0,         0, 32'h0);
    tbl[22] = mk(0, 5'd0, 32'h0,        0, 0, 0,  0, 0, 5'd0, 32'h0,         0, 32'h0,         0, 32'h0);

    rst = 1'b0;
    drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
    #22;
    rst = 1'b1;
    #1;
    check_all(0, 0, 5'd0, 32'h0, 0, 32'h0, 0, 32'h0);
    next_cycle();

    // Directed table
    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].st, tbl[i].b1, tbl[i].b2);
      @(negedge clock);
      check_all(tbl[i].cnt, tbl[i].we, tbl[i].ws, tbl[i].wd,
                tbl[i].h1, tbl[i].bd1, tbl[i].h2, tbl[i].bd2);
      next_cycle();
    end

    // Two entries held, then continuous accept while draining
    drive(1, 5'd10, 32'hA0, 1, 5'd0, 5'd0);
    @(negedge clock); chk("sim_cnt_pre0", 32'(count), 32'd0);
    next_cycle();
    drive(1, 5'd11, 32'hB0, 1, 5'd0, 5'd0);
    @(negedge clock); chk("sim_cnt_pre1", 32'(count), 32'd1);
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      drive(1, 5'(12 + k), 32'(16'hC0 + k), 0, 5'd0, 5'd0);
      @(negedge clock);
      chk("sim_count", 32'(count), 32'd2);
      chk("sim_we", 32'(wr_we), 32'd1);
      chk("sim_wr_sel", 32'(wr_sel), 32'(10 + k));
      next_cycle();
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
      @(negedge clock);
      chk("sim_tail_count", 32'(count), 32'(2 - k));
      chk("sim_tail_sel", 32'(wr_sel), (k < 2) ? 32'(14 + k) : 32'd0);
      next_cycle();
    end

    // Three entries pending, reset between edges
    for (int k = 0; k < 3; k++) begin
      drive(1, 5'(20 + k), 32'(32'h500 + k), 1, 5'd0, 5'd0);
      next_cycle();
    end
    drive(0, 5'd0, 32'h0, 0, 5'd20, 5'd21);
    chk("rst_pre_count", 32'(count), 32'd3);
    #1 rst = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_we", 32'(wr_we), 32'd0);
    chk("rst_byp_hit_1", 32'(byp_hit_1), 32'd0);
    #1 rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("post_rst_we", 32'(wr_we), 32'd0);
      chk("post_rst_count", 32'(count), 32'd0);
      next_cycle();
    end

    // Randomized traffic against the reference queue
    mdl.delete();
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      @(negedge clock);
      model_expect(e_cnt, e_we, e_ws, e_wd, e_h1, e_bd1, e_h2, e_bd2);
      check_all(e_cnt, e_we, e_ws, e_wd, e_h1, e_bd1, e_h2, e_bd2);
      @(posedge clock);
      model_update();
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/regfile_write_queue.md
Name: regfile_write_queue

Overview:
- Writer-side companion to the 32x32 register file.
- Accepts register write requests from the execute/memory stages and buffers them in a small FIFO. Drains one entry per cycle onto the register file's write port (write select, data, write enable).
- Gives the decode stage a bypass lookup, so reads of a register with a pending, not-yet-written value return the queued value instead of stale file contents.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- CW, 3, width of the count output; equals log2(DEPTH)+1.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- in_valid  input  1  write request present.
- in_ready  output  1  queue can accept a request this cycle.
- in_sel  input  5  destination register index.
- in_data  input  32  value to write.
- wr_stall  input  1  1 = register file not accepting a write this cycle.
- wr_we  output  1  write enable to the register file.
- wr_sel  output  5  write select to the register file.
- wr_data  output  32  write data to the register file.
- byp_sel_1  input  5  first read select under lookup.
- byp_sel_2  input  5  second read select under lookup.
- byp_hit_1  output  1  a pending entry matches byp_sel_1.
- byp_hit_2  output  1  a pending entry matches byp_sel_2.
- byp_data_1  output  32  data of the youngest entry matching byp_sel_1; 0 when there is no hit.
- byp_data_2  output  32  data of the youngest entry matching byp_sel_2; 0 when there is no hit.
- count  output  CW  number of occupied entries.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.

Behaviour:
- Reset (rst low, asynchronous):
  - Read pointer, write pointer and count clear to 0.
  - All entry storage clears to sel=0, data=0.
  - Outputs: wr_we=0, wr_sel=0, wr_data=0, byp_hit_*=0, byp_data_*=0, count=0, empty=1, full=0, in_ready=1.
  - Reset asserted mid-operation discards every pending entry; nothing is written to the register file afterwards.
- Storage: circular buffer of DEPTH entries {sel[4:0], data[31:0]}. Pointers are log2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
- in_ready = !full. It does not depend on a same-cycle dequeue: a full queue refuses input even while draining.
- Accept: on a rising edge with in_valid && in_ready.
  - in_sel != 0: write {in_sel, in_data} at the write pointer and increment the write pointer.
  - in_sel == 0: the request is accepted (handshake completes) but discarded. No entry, no count change. Register 0 is hardwired zero.
- Drain output (combinational from the head entry):
  - wr_we = !empty && !wr_stall.
  - wr_sel/wr_data = head entry when !empty, otherwise 0.
  - On a rising edge with wr_we=1, the head is consumed and the read pointer increments.
  - wr_stall=1 holds the head; wr_sel/wr_data stay stable.
- Latency: a request accepted at edge N appears on wr_* during cycle N+1 when it reaches the head of an empty queue. It is written at edge N+1 at the earliest. There is no same-cycle pass-through.
- Simultaneous accept (non-zero sel) and drain: both occur and count is unchanged. Accept alone: count+1. Drain alone: count-1. Count never exceeds DEPTH or goes below 0.
- Ordering: strict FIFO. Multiple entries to the same register are written in arrival order.
- Bypass (purely combinational, evaluated independently for each port):
  - Scans all occupied entries, including the head being drained this cycle.
  - Hit when an occupied entry's sel equals byp_sel_k and byp_sel_k != 0.
  - With several matches, the youngest entry (closest to the write pointer) supplies byp_data_k.
  - The in_* request of the current cycle is not visible to the bypass until it is enqueued.
  - byp_sel_k == 0 never hits.
- count, empty and full are derived from the registered count and change only on rising edges or on reset.

Test Plan:
- Reset, then one write {sel=5, data=0xDEADBEEF} with wr_stall=0 -> at edge 1 count=1; cycle 1 wr_we=1, wr_sel=5, wr_data=0xDEADBEEF; after edge 2 empty=1, wr_we=0.
- Hold wr_stall=1 and enqueue sel 1,2,3,4 with data 0x11,0x22,0x33,0x44 -> full=1, in_ready=0, count=4. A fifth request (sel 6) is not accepted. Release the stall -> writes issue 1,2,3,4 on consecutive cycles; pointers wrap correctly on a second fill.
- Stall, enqueue {7,0xAAAA} then {7,0xBBBB}, byp_sel_1=7 -> byp_hit_1=1, byp_data_1=0xBBBB. byp_sel_2=8 -> byp_hit_2=0, byp_data_2=0.
- Enqueue {sel=0, data=0x1234} -> in_ready=1 and the handshake completes; count stays 0, wr_we stays 0. byp_sel_1=0 -> no hit.
- Queue holding 2 entries, no stall, continuous in_valid with new entries -> count stays 2 each cycle (simultaneous accept and drain); wr_sel sequence matches input order.
- Queue holding 3 entries, drive rst=0 between clock edges -> count=0, empty=1 and wr_we=0 immediately. After release, no stale entry is ever written.
